// File: rtl/fp_pkg.sv
// Shared floating-point helpers: field widths derived from the total width,
// exponent constants, raw-magnitude bit positions and the post-add FSM types.
package fp_pkg;

    function automatic int exp_width(input int n);
        return n / 4;
    endfunction

    function automatic int mant_width(input int n);
        return n - n / 4;
    endfunction

    function automatic int exp_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    function automatic int exp_max(input int ew);
        return (1 << ew) - 1;
    endfunction

    localparam int FP_N       = 32;
    localparam int FP_EW      = exp_width(FP_N);
    localparam int FP_BIAS    = exp_bias(FP_EW);
    localparam int FP_EXP_MAX = exp_max(FP_EW);

    // Raw magnitude layout: {carry, hidden, fraction, guard, round, sticky}.
    localparam int S_BIT    = 0;
    localparam int R_BIT    = 1;
    localparam int G_BIT    = 2;
    localparam int FRAC_LSB = 3;

    function automatic int hidden_pos(input int mw);
        return mw + 2;
    endfunction

    function automatic int carry_pos(input int mw);
        return mw + 3;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

    // How the ROUND state packs the item it holds.
    typedef enum logic [1:0] {
        K_NORMAL,
        K_ZERO,
        K_SPECIAL
    } kind_t;

endpackage

// File: rtl/fp_norm_round_if.sv
// Raw-sum input and packed-result output handshakes of the normalise/round stage.
interface fp_norm_round_if
    import fp_pkg::*;
#(
    parameter int N = 32
);
    localparam int EW = exp_width(N);
    localparam int MW = mant_width(N);

    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [EW-1:0] in_exp;
    logic [MW+3:0] in_mag;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_result;
    logic          out_overflow;
    logic          out_underflow;

    modport master (
        output in_valid, in_sign, in_exp, in_mag, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mag, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow
    );

endinterface

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even increment at the fraction LSB, with carry-out detect.
module fp_rne_round
    import fp_pkg::*;
#(
    parameter int MW = 24
) (
    input  logic [MW+3:0] mag,
    output logic [MW+3:0] mag_rnd,
    output logic          carry
);
    logic inc;

    // Ties go up only when the kept LSB is odd.
    assign inc     = mag[G_BIT] & (mag[R_BIT] | mag[S_BIT] | mag[FRAC_LSB]);
    assign mag_rnd = mag + {{MW{1'b0}}, inc, 3'b000};
    assign carry   = mag_rnd[carry_pos(MW)];

endmodule

// File: rtl/fp_norm_round.sv
// Post-add stage: iterative left normalise, RNE round, over/underflow handling
// and packing into an N-bit IEEE-style word.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_norm_round_if.slave bus,
    output logic           busy
);
    localparam int EW    = exp_width(N);
    localparam int MW    = mant_width(N);
    localparam int MAG_W = MW + 4;
    localparam int XW    = EW + 2;
    localparam int C_BIT = carry_pos(MW);
    localparam int H_BIT = hidden_pos(MW);
    localparam logic signed [XW-1:0] EXP_TOP = XW'(exp_max(EW));

    state_t                 state_q, state_d;
    kind_t                  kind_q, kind_d;
    logic                   sign_q, sign_d;
    logic signed [XW-1:0]   exp_q, exp_d, exp_r;
    logic [MAG_W-1:0]       mag_q, mag_d, mag_r;
    logic [N-1:0]           result_q, result_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
    logic [MAG_W-1:0]       mag_rnd;
    logic                   rnd_carry;

    fp_rne_round #(.MW(MW)) u_rne (
        .mag     (mag_q),
        .mag_rnd (mag_rnd),
        .carry   (rnd_carry)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d  = state_q;
        kind_d   = kind_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mag_d    = mag_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        exp_r    = exp_q;
        mag_r    = mag_rnd;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d = bus.in_sign;
                    exp_d  = {2'b00, bus.in_exp};
                    mag_d  = bus.in_mag;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    if (&bus.in_exp) begin
                        kind_d  = K_SPECIAL;
                        state_d = ROUND;
                    end else begin
                        kind_d  = K_NORMAL;
                        state_d = NORM;
                    end
                end
            end

            NORM: begin
                if (mag_q == '0) begin
                    sign_d  = 1'b0;
                    kind_d  = K_ZERO;
                    state_d = ROUND;
                end else if (mag_q[C_BIT]) begin
                    // Bits shifted out on the right fold into sticky.
                    mag_d   = {1'b0, mag_q[MAG_W-1:2], |mag_q[1:0]};
                    exp_d   = exp_q + XW'(1);
                    state_d = ROUND;
                end else if (mag_q[H_BIT]) begin
                    state_d = ROUND;
                end else if (exp_q <= XW'(1)) begin
                    mag_d   = '0;
                    kind_d  = K_ZERO;
                    unf_d   = 1'b1;
                    state_d = ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - XW'(1);
                end
            end

            ROUND: begin
                unique case (kind_q)
                    K_ZERO:    result_d = {sign_q, {(N-1){1'b0}}};
                    K_SPECIAL: result_d = {sign_q, exp_q[EW-1:0], mag_q[H_BIT-1:FRAC_LSB]};
                    default: begin
                        if (rnd_carry) begin
                            mag_r = {1'b0, mag_rnd[MAG_W-1:1]};
                            exp_r = exp_q + XW'(1);
                        end
                        if (exp_r >= EXP_TOP) begin
                            result_d = {sign_q, {EW{1'b1}}, {(MW-1){1'b0}}};
                            ovf_d    = 1'b1;
                        end else begin
                            result_d = {sign_q, exp_r[EW-1:0], mag_r[H_BIT-1:FRAC_LSB]};
                        end
                        mag_d = mag_r;
                        exp_d = exp_r;
                    end
                endcase
                state_d = DONE;
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            kind_q   <= K_NORMAL;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mag_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q  <= state_d;
            kind_q   <= kind_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mag_q    <= mag_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.out_valid     = (state_q == DONE);
    assign bus.out_result    = result_q;
    assign bus.out_overflow  = ovf_q;
    assign bus.out_underflow = unf_q;
    assign busy              = (state_q != IDLE);

endmodule
